// File: rtl/zynq_axi_pkg.sv
// Shared AXI3 types for the Zynq DRAM-port stand-in: response/burst codes,
// responder FSM states and the AXI3 burst length width.
package zynq_axi_pkg;

    localparam int axi_len_w = 4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/zynq_axi_mem_bank.sv
// Word array behind the AXI responder: one byte-masked synchronous write
// port and one asynchronous read port (read sees pre-write data in a cycle).
module zynq_axi_mem_bank #(
    parameter int data_width_p = 64,
    parameter int mem_els_p    = 4096,
    localparam int idx_w       = $clog2(mem_els_p),
    localparam int strb_w      = data_width_p / 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [idx_w-1:0]        waddr,
    input  logic [data_width_p-1:0] wdata,
    input  logic [strb_w-1:0]       wstrb,
    input  logic [idx_w-1:0]        raddr,
    output logic [data_width_p-1:0] rdata
);

    logic [data_width_p-1:0] mem [mem_els_p];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < strb_w; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi3_burst_mem_responder.sv
// AXI3 INCR-burst memory responder standing in for the PS DDR port; one
// outstanding transaction per direction, read and write channels independent.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting exactly awlen+1 beats
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, one beat per rready, rlast on beat arlen
module axi3_burst_mem_responder
    import zynq_axi_pkg::*;
#(
    parameter int                      addr_width_p = 32,
    parameter int                      data_width_p = 64,
    parameter int                      id_width_p   = 6,
    parameter int                      mem_els_p    = 4096,
    parameter logic [addr_width_p-1:0] base_addr_p  = 32'h0000_0000
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic [id_width_p-1:0]     s_axi_awid,
    input  logic [addr_width_p-1:0]   s_axi_awaddr,
    input  logic [axi_len_w-1:0]      s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [id_width_p-1:0]     s_axi_wid,
    input  logic [data_width_p-1:0]   s_axi_wdata,
    input  logic [data_width_p/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [id_width_p-1:0]     s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [id_width_p-1:0]     s_axi_arid,
    input  logic [addr_width_p-1:0]   s_axi_araddr,
    input  logic [axi_len_w-1:0]      s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [id_width_p-1:0]     s_axi_rid,
    output logic [data_width_p-1:0]   s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int idx_w  = $clog2(mem_els_p);
    localparam int size_c = $clog2(data_width_p / 8);

    // Decode errors win over format errors; both suppress the array access.
    function automatic axi_resp_e check_req(input logic [addr_width_p-1:0] addr,
                                            input logic [axi_len_w-1:0]    len,
                                            input logic [2:0]              size,
                                            input logic [1:0]              burst);
        logic [addr_width_p-1:0] off;
        logic [addr_width_p:0]   last_word;
        off       = addr - base_addr_p;
        last_word = {1'b0, off >> size_c} + {{(addr_width_p + 1 - axi_len_w){1'b0}}, len};
        if (addr < base_addr_p || last_word >= (addr_width_p + 1)'(mem_els_p)) return RESP_DECERR;
        if (burst != BURST_INCR || size != 3'(size_c) || off[size_c-1:0] != '0) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [idx_w-1:0] word_idx(input logic [addr_width_p-1:0] addr);
        return idx_w'((addr - base_addr_p) >> size_c);
    endfunction

    w_state_e              w_state;
    logic [id_width_p-1:0] w_id;
    logic [idx_w-1:0]      w_idx;
    logic [axi_len_w-1:0]  w_len;
    logic [axi_len_w-1:0]  w_beat;
    axi_resp_e             w_resp;

    r_state_e              r_state;
    logic [idx_w-1:0]      r_idx;
    logic [axi_len_w-1:0]  r_len;
    logic [axi_len_w-1:0]  r_beat;

    logic                    w_beat_err;
    logic                    mem_we;
    logic [data_width_p-1:0] mem_rdata;

    assign w_beat_err = (s_axi_wlast != (w_beat == w_len)) || (s_axi_wid != w_id);
    assign mem_we     = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready &&
                        (w_resp == RESP_OKAY) && !w_beat_err;

    zynq_axi_mem_bank #(
        .data_width_p (data_width_p),
        .mem_els_p    (mem_els_p)
    ) mem_bank (
        .clk   (s_axi_aclk),
        .we    (mem_we),
        .waddr (w_idx),
        .wdata (s_axi_wdata),
        .wstrb (s_axi_wstrb),
        .raddr (r_idx),
        .rdata (mem_rdata)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= '0;
            w_id          <= '0;
            w_idx         <= '0;
            w_len         <= '0;
            w_beat        <= '0;
            w_resp        <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awvalid && s_axi_awready) begin
                        w_id          <= s_axi_awid;
                        w_idx         <= word_idx(s_axi_awaddr);
                        w_len         <= s_axi_awlen;
                        w_beat        <= '0;
                        w_resp        <= check_req(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid && s_axi_wready) begin
                        w_idx  <= w_idx + 1'b1;
                        w_beat <= w_beat + 1'b1;
                        if (w_beat_err && w_resp == RESP_OKAY) w_resp <= RESP_SLVERR;
                        // Burst ends on the beat count regardless of wlast.
                        if (w_beat == w_len) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= w_id;
                            s_axi_bresp  <= (w_beat_err && w_resp == RESP_OKAY) ? RESP_SLVERR : w_resp;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rresp   <= '0;
            r_idx         <= '0;
            r_len         <= '0;
            r_beat        <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_idx         <= word_idx(s_axi_araddr);
                        r_len         <= s_axi_arlen;
                        r_beat        <= '0;
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rresp   <= check_req(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
                        s_axi_rlast   <= (s_axi_arlen == '0);
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_idx       <= r_idx + 1'b1;
                        r_beat      <= r_beat + 1'b1;
                        s_axi_rlast <= (r_beat + 1'b1 == r_len);
                        if (r_beat == r_len) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Errored bursts still produce their beats, but with zero data.
    assign s_axi_rdata = (s_axi_rvalid && s_axi_rresp == RESP_OKAY) ? mem_rdata : '0;

endmodule

// File: tb/tb_axi3_burst_mem_responder.sv
// Scoreboard bench for axi3_burst_mem_responder: drivers push expected B/R
// responses, negedge monitors pop and compare on every handshake.
module tb_axi3_burst_mem_responder;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  s_axi_awid = '0;
    logic [31:0] s_axi_awaddr = '0;
    logic [3:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = '0;
    logic [1:0]  s_axi_awburst = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [5:0]  s_axi_wid = '0;
    logic [63:0] s_axi_wdata = '0;
    logic [7:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [5:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [5:0]  s_axi_arid = '0;
    logic [31:0] s_axi_araddr = '0;
    logic [3:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = '0;
    logic [1:0]  s_axi_arburst = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [5:0]  s_axi_rid;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    always #5 clk = ~clk;

    axi3_burst_mem_responder dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wid     (s_axi_wid),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    typedef struct {
        logic [5:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [5:0]  id;
        logic [1:0]  resp;
        logic        last;
        logic [63:0] data;
        logic [63:0] alt;
    } r_exp_t;

    b_exp_t exp_b[$];
    r_exp_t exp_r[$];

    int n_checks = 0;
    int n_fail   = 0;
    int b_count  = 0;
    int r_count  = 0;

    logic [63:0] model [4096];
    logic [63:0] wbuf [16];
    logic [7:0]  sbuf [16];
    logic [63:0] ebuf [16];
    logic [63:0] abuf [16];

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitors: every handshake consumes exactly one expected entry.
    always @(negedge clk) begin
        b_exp_t be;
        r_exp_t re;
        if (rst_n && s_axi_bvalid && s_axi_bready) begin
            if (exp_b.size() == 0) begin
                check(1'b0, "b_extra", 64'(s_axi_bid), 64'(0));
            end else begin
                be = exp_b.pop_front();
                check({s_axi_bid, s_axi_bresp} == {be.id, be.resp}, "b_id_resp",
                      64'({s_axi_bid, s_axi_bresp}), 64'({be.id, be.resp}));
            end
            b_count++;
        end
        if (rst_n && s_axi_rvalid && s_axi_rready) begin
            if (exp_r.size() == 0) begin
                check(1'b0, "r_extra", s_axi_rdata, 64'(0));
            end else begin
                re = exp_r.pop_front();
                check(s_axi_rdata == re.data || s_axi_rdata == re.alt, "r_data", s_axi_rdata, re.data);
                check({s_axi_rid, s_axi_rresp, s_axi_rlast} == {re.id, re.resp, re.last}, "r_id_resp_last",
                      64'({s_axi_rid, s_axi_rresp, s_axi_rlast}), 64'({re.id, re.resp, re.last}));
            end
            r_count++;
        end
    end

    // ch: 0=AW, 1=W, 2=AR. Returns after the posedge on which the handshake happened.
    task automatic wait_hs(input int ch, output bit ok);
        bit hs;
        ok = 1'b0;
        for (int n = 0; n < TMO && !ok; n++) begin
            @(negedge clk);
            case (ch)
                0:       hs = s_axi_awready;
                1:       hs = s_axi_wready;
                default: hs = s_axi_arready;
            endcase
            @(posedge clk);
            #1;
            ok = hs;
        end
        if (!ok) check(1'b0, "hs_timeout", 64'(ch), 64'(1));
    endtask

    task automatic axi_write(input logic [5:0] id, input logic [5:0] wid, input logic [31:0] addr,
                             input logic [3:0] len, input logic [1:0] burst, input logic [2:0] size,
                             input logic [1:0] exp_resp, input bit bp);
        bit ok;
        int target;
        int n;
        int idx;
        int k;
        exp_b.push_back('{id, exp_resp});
        target = b_count + 1;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awburst = burst; s_axi_awsize = size; s_axi_awvalid = 1'b1;
        wait_hs(0, ok);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            k = bp ? int'($urandom_range(0, 2)) : 0;
            repeat (k) begin @(posedge clk); #1; end
            s_axi_wid = wid; s_axi_wdata = wbuf[i]; s_axi_wstrb = sbuf[i];
            s_axi_wlast = (i == int'(len)); s_axi_wvalid = 1'b1;
            wait_hs(1, ok);
            s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
            if (exp_resp == 2'b00) begin
                idx = (int'(addr >> 3) + i) % 4096;
                for (int b = 0; b < 8; b++) if (sbuf[i][b]) model[idx][b*8 +: 8] = wbuf[i][b*8 +: 8];
            end
        end
        n = 0;
        while (b_count < target && n < TMO) begin
            s_axi_bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        s_axi_bready = 1'b0;
        if (b_count < target) check(1'b0, "b_timeout", 64'(b_count), 64'(target));
    endtask

    // mode 0: expect model; 1: expect ebuf; 2: model (old) or abuf (new) per word.
    task automatic axi_read(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input logic [1:0] exp_resp,
                            input bit bp, input int mode);
        bit ok;
        int target;
        int n;
        int idx;
        logic [63:0] d;
        for (int i = 0; i <= int'(len); i++) begin
            idx = (int'(addr >> 3) + i) % 4096;
            d = (mode == 1) ? ebuf[i] : model[idx];
            if (exp_resp != 2'b00) d = '0;
            exp_r.push_back('{id, exp_resp, (i == int'(len)), d, (mode == 2) ? abuf[i] : d});
        end
        target = r_count + int'(len) + 1;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arburst = burst; s_axi_arsize = size; s_axi_arvalid = 1'b1;
        wait_hs(2, ok);
        s_axi_arvalid = 1'b0;
        n = 0;
        while (r_count < target && n < TMO) begin
            s_axi_rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        s_axi_rready = 1'b0;
        if (r_count < target) check(1'b0, "r_timeout", 64'(r_count), 64'(target));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;

        // Reset state and first cycle after release
        repeat (3) @(posedge clk);
        #1;
        check({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
               s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid} == '0, "reset_ctrl",
              64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast}), 64'(0));
        check(s_axi_rdata == '0, "reset_rdata", s_axi_rdata, 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check(s_axi_awready && s_axi_arready, "ready_after_reset",
              64'({s_axi_awready, s_axi_arready}), 64'(3));

        // 8-beat INCR write then readback with explicit expectations
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 64'h1000 + 64'(i); sbuf[i] = 8'hFF; ebuf[i] = 64'h1000 + 64'(i);
        end
        axi_write(6'h2A, 6'h2A, 32'h40, 4'd7, 2'b01, 3'd3, 2'b00, 1'b0);
        axi_read(6'h2A, 32'h40, 4'd7, 2'b01, 3'd3, 2'b00, 1'b0, 1);

        // Partial strobe on one word
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
        axi_write(6'h01, 6'h01, 32'h400, 4'd0, 2'b01, 3'd3, 2'b00, 1'b0);
        wbuf[0] = 64'h0; sbuf[0] = 8'h0F;
        axi_write(6'h01, 6'h01, 32'h400, 4'd0, 2'b01, 3'd3, 2'b00, 1'b0);
        ebuf[0] = 64'hFFFF_FFFF_0000_0000;
        axi_read(6'h03, 32'h400, 4'd0, 2'b01, 3'd3, 2'b00, 1'b0, 1);

        // Out of range at the top of the array: DECERR, array untouched
        wbuf[0] = 64'h5555_0000_0000_0FFE; wbuf[1] = 64'h5555_0000_0000_0FFF;
        sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
        axi_write(6'h04, 6'h04, 32'h7FF0, 4'd1, 2'b01, 3'd3, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin wbuf[i] = 64'hDEAD_0000 + 64'(i); sbuf[i] = 8'hFF; end
        axi_write(6'h05, 6'h05, 32'h7FF0, 4'd3, 2'b01, 3'd3, 2'b11, 1'b0);
        axi_read(6'h06, 32'h7FF0, 4'd1, 2'b01, 3'd3, 2'b00, 1'b0, 0);
        axi_read(6'h07, 32'h7FF0, 4'd2, 2'b01, 3'd3, 2'b11, 1'b0, 0);

        // FIXED burst read: SLVERR with zero data, then INCR recovers
        axi_read(6'h08, 32'h40, 4'd1, 2'b00, 3'd3, 2'b10, 1'b0, 0);
        axi_read(6'h09, 32'h40, 4'd1, 2'b01, 3'd3, 2'b00, 1'b0, 0);

        // wid mismatch and unaligned/size errors: SLVERR, no write
        wbuf[0] = 64'hBAD0; sbuf[0] = 8'hFF;
        axi_write(6'h11, 6'h12, 32'h40, 4'd0, 2'b01, 3'd3, 2'b10, 1'b0);
        axi_write(6'h13, 6'h13, 32'h48, 4'd0, 2'b01, 3'd2, 2'b10, 1'b0);
        axi_read(6'h14, 32'h40, 4'd1, 2'b01, 3'd3, 2'b00, 1'b0, 0);
        axi_read(6'h15, 32'h44, 4'd0, 2'b01, 3'd3, 2'b10, 1'b0, 0);

        // Concurrent overlapping read and write with backpressure
        for (int i = 0; i < 8; i++) begin wbuf[i] = 64'hC0C0_0000 + 64'(i); sbuf[i] = 8'hFF; end
        axi_write(6'h20, 6'h20, 32'h960, 4'd7, 2'b01, 3'd3, 2'b00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 64'hD0D0_1111_0000_0000 + 64'(i); abuf[i] = wbuf[i];
        end
        fork
            axi_write(6'h21, 6'h21, 32'h960, 4'd7, 2'b01, 3'd3, 2'b00, 1'b1);
            axi_read(6'h22, 32'h960, 4'd7, 2'b01, 3'd3, 2'b00, 1'b1, 2);
        join
        axi_read(6'h23, 32'h960, 4'd7, 2'b01, 3'd3, 2'b00, 1'b1, 0);

        // Reset in the middle of a write burst, during beat 3 of 8
        for (int i = 0; i < 8; i++) begin wbuf[i] = 64'hA0 + 64'(i); sbuf[i] = 8'hFF; end
        axi_write(6'h30, 6'h30, 32'h640, 4'd7, 2'b01, 3'd3, 2'b00, 1'b0);
        s_axi_awid = 6'h31; s_axi_awaddr = 32'h640; s_axi_awlen = 4'd7;
        s_axi_awburst = 2'b01; s_axi_awsize = 3'd3; s_axi_awvalid = 1'b1;
        wait_hs(0, ok);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_axi_wid = 6'h31; s_axi_wdata = 64'hB0 + 64'(i); s_axi_wstrb = 8'hFF;
            s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
            wait_hs(1, ok);
            model[200 + i] = 64'hB0 + 64'(i);
        end
        s_axi_wdata = 64'hB3;
        #2;
        rst_n = 1'b0;
        #1;
        check({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
               s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid} == '0, "midburst_reset_ctrl",
              64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast}), 64'(0));
        check(s_axi_rdata == '0, "midburst_reset_rdata", s_axi_rdata, 64'(0));
        s_axi_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check(s_axi_awready && s_axi_arready, "ready_after_midburst_reset",
              64'({s_axi_awready, s_axi_arready}), 64'(3));
        axi_read(6'h32, 32'h640, 4'd7, 2'b01, 3'd3, 2'b00, 1'b0, 0);

        repeat (4) @(posedge clk);
        #1;
        check(exp_b.size() == 0, "b_queue_drained", 64'(exp_b.size()), 64'(0));
        check(exp_r.size() == 0, "r_queue_drained", 64'(exp_r.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
